// File: rtl/fetch_unit_pkg.sv
// Shared CPU-internal definitions for the fetch stage: state encodings,
// opcode field geometry and the branch offset field.
package fetch_unit_pkg;

  // Fetch sequencer states. ST_FAULT is only reachable when the fetch
  // watchdog is built in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  // The opcode occupies the top OP_W bits of the instruction word.
  localparam int OP_W = 4;

  // The branch displacement is a signed field at the bottom of the word.
  localparam int BR_OFF_LSB = 0;
  localparam int BR_OFF_W   = 6;

endpackage

// File: rtl/fetch_pcnext.sv
// Combinational next-PC selection for the fetch stage.
// The priority is JUMP, then BRANCH, then sequential. All arithmetic wraps
// modulo 2^PCW.
module fetch_pcnext
  import fetch_unit_pkg::*;
#(
  parameter int IW  = 16,
  parameter int PCW = 8
) (
  input  logic [PCW-1:0] pc,
  input  logic [IW-1:0]  instr,
  input  logic           jump,
  input  logic           branch,
  output logic [PCW-1:0] pc_next
);

  localparam logic [PCW-1:0] PC_ONE = PCW'(1);

  logic [BR_OFF_W-1:0] br_off;
  logic [PCW-1:0]      br_off_sext;
  logic [PCW-1:0]      pc_inc;

  assign br_off      = instr[BR_OFF_LSB +: BR_OFF_W];
  assign br_off_sext = {{(PCW - BR_OFF_W){br_off[BR_OFF_W-1]}}, br_off};
  assign pc_inc      = pc + PC_ONE;

  // Select the next PC. JUMP overrides BRANCH when both are asserted.
  always_comb begin
    pc_next = pc_inc;
    if (jump) begin
      pc_next = instr[PCW-1:0];
    end else if (branch) begin
      pc_next = pc_inc + br_off_sext;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program-counter and instruction-fetch stage.
// This stage owns the PC and fetches one word per step over a req/ack
// handshake. It presents each fetched word for exactly one EXEC cycle, and
// it applies the JUMP/BRANCH decision from the control unit at the end of
// that cycle.
// Optional build macro: FETCH_TIMEOUT_EN. When it is defined, a watchdog
// limits how long a fetch may wait for its ack. When the watchdog expires,
// the stage parks in a sticky FAULT state.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int             IW       = 16,
  parameter int             PCW      = 8,
  parameter logic [PCW-1:0] RESET_PC = '0,
  parameter int             TIMEOUT  = 64
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ireq,
  output logic [PCW-1:0]  iaddr,
  input  logic            iack,
  input  logic [IW-1:0]   idata,
  input  logic            stall,
  input  logic            jump,
  input  logic            branch,
  output logic [OP_W-1:0] op,
  output logic [IW-1:0]   instr,
  output logic            exec,
  output logic [PCW-1:0]  pc,
  output logic            fault
);

  fetch_state_t   state;
  fetch_state_t   state_nxt;
  logic [PCW-1:0] pc_next;

  fetch_pcnext #(
    .IW (IW),
    .PCW(PCW)
  ) u_pcnext (
    .pc     (pc),
    .instr  (instr),
    .jump   (jump),
    .branch (branch),
    .pc_next(pc_next)
  );

  assign iaddr = pc;
  assign op    = instr[IW-1 -: OP_W];

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wdog;
  logic            wdog_expired;

  // The watchdog expires on the last permitted un-acked FETCH cycle.
  assign wdog_expired = (wdog == WD_W'(TIMEOUT - 1));

  // Count consecutive un-acked FETCH cycles. Leaving FETCH clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == ST_FETCH && !iack) begin
      wdog <= wdog + WD_W'(1);
    end else begin
      wdog <= '0;
    end
  end
`endif

  // State, PC and instruction registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && iack) begin
        instr <= idata;
      end
      if (state == ST_EXEC) begin
        pc <= pc_next;
      end
    end
  end

  // Next-state and Moore outputs of the fetch sequencer.
  // NOTE: every output gets a default before the case, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ireq      = 1'b0;
    exec      = 1'b0;
    fault     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!stall) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ireq = 1'b1;
        if (iack) begin
          state_nxt = ST_EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wdog_expired) begin
          state_nxt = ST_FAULT;
        end
`endif
      end
      ST_EXEC: begin
        exec      = 1'b1;
        state_nxt = stall ? ST_IDLE : ST_FETCH;
      end
`ifdef FETCH_TIMEOUT_EN
      ST_FAULT: begin
        fault = 1'b1;
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// The bench drives inputs and samples outputs on the falling clock edge.
// Directed vectors come from a table. A randomized phase follows, and it is
// checked against a next-PC reference model. Hand-written sequences then
// cover reset during a fetch and the watchdog behaviour.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq;
  logic [7:0]  iaddr;
  logic        iack;
  logic [15:0] idata;
  logic        stall;
  logic        jump;
  logic        branch;
  logic [3:0]  op;
  logic [15:0] instr;
  logic        exec;
  logic [7:0]  pc;
  logic        fault;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .IW      (16),
    .PCW     (8),
    .RESET_PC(8'h00),
    .TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ireq  (ireq),
    .iaddr (iaddr),
    .iack  (iack),
    .idata (idata),
    .stall (stall),
    .jump  (jump),
    .branch(branch),
    .op    (op),
    .instr (instr),
    .exec  (exec),
    .pc    (pc),
    .fault (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Next-PC reference: signed displacement arithmetic, reduced modulo 256.
  function automatic logic [7:0] ref_next(input logic [7:0] p, input logic [15:0] w,
                                          input bit j, input bit b);
    int off;
    int t;
    off = int'(w[5:0]);
    if (off >= 32) off -= 64;
    if (j)      t = int'(w[7:0]);
    else if (b) t = int'(p) + 1 + off;
    else        t = int'(p) + 1;
    t = ((t % 256) + 256) % 256;
    return t[7:0];
  endfunction

  typedef struct {
    logic [15:0] word;
    int          wait_n;
    bit          j;
    bit          b;
    bit          s;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vecs[12];

  // Carry one instruction through FETCH (with wait_n un-acked cycles) and EXEC.
  task automatic run_instr(input string tag, input logic [15:0] word, input int wait_n,
                           input bit j, input bit b, input bit s,
                           input logic [7:0] exp_addr, input logic [7:0] exp_pc);
    int budget;
    budget = 20;
    while (!ireq && budget > 0) begin
      jump   = 1'($urandom);
      branch = 1'($urandom);
      @(negedge clk);
      budget--;
    end
    check({tag, " ireq_seen"}, 32'(ireq), 32'd1);
    for (int k = 0; k < wait_n; k++) begin
      check({tag, " wait_ireq_exec"}, {30'd0, ireq, exec}, 32'b10);
      check({tag, " wait_iaddr"}, 32'(iaddr), 32'(exp_addr));
      iack   = 1'b0;
      idata  = 16'($urandom);
      jump   = 1'($urandom);
      branch = 1'($urandom);
      stall  = 1'($urandom);
      @(negedge clk);
    end
    check({tag, " ack_ireq_exec"}, {30'd0, ireq, exec}, 32'b10);
    check({tag, " ack_iaddr"}, 32'(iaddr), 32'(exp_addr));
    iack   = 1'b1;
    idata  = word;
    stall  = 1'($urandom);
    jump   = 1'($urandom);
    branch = 1'($urandom);
    @(negedge clk);
    iack  = 1'($urandom);
    idata = 16'($urandom);
    check({tag, " exec"}, {30'd0, ireq, exec}, 32'b01);
    check({tag, " op"}, 32'(op), 32'(word[15:12]));
    check({tag, " instr"}, 32'(instr), 32'(word));
    check({tag, " pc_in_exec"}, 32'(pc), 32'(exp_addr));
    jump   = j;
    branch = b;
    stall  = s;
    @(negedge clk);
    iack   = 1'b0;
    jump   = 1'($urandom);
    branch = 1'($urandom);
    check({tag, " exec_done"}, 32'(exec), 32'd0);
    check({tag, " next_pc"}, 32'(pc), 32'(exp_pc));
    check({tag, " ireq_after"}, 32'(ireq), 32'(!s));
    if (s) begin
      repeat (1 + $urandom_range(2)) begin
        check({tag, " stall_idle"}, 32'(ireq), 32'd0);
        check({tag, " stall_pc"}, 32'(pc), 32'(exp_pc));
        @(negedge clk);
      end
      stall = 1'b0;
      @(negedge clk);
      check({tag, " resume_ireq"}, 32'(ireq), 32'd1);
      check({tag, " resume_iaddr"}, 32'(iaddr), 32'(exp_pc));
    end
  endtask

  initial begin
    int         budget;
    logic [7:0] pc_m;
    logic [7:0] nxt;
    logic [15:0] w;
    bit         j;
    bit         b;
    bit         s;

    vecs[0]  = '{16'h1234, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01};
    vecs[1]  = '{16'hA5C3, 3, 1'b0, 1'b0, 1'b0, 8'h01, 8'h02};
    vecs[2]  = '{16'h3040, 0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h40};
    vecs[3]  = '{16'h5F40, 1, 1'b1, 1'b1, 1'b0, 8'h40, 8'h40};
    vecs[4]  = '{16'h2010, 0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h10};
    vecs[5]  = '{16'h613E, 2, 1'b0, 1'b1, 1'b0, 8'h10, 8'h0F};
    vecs[6]  = '{16'h70FF, 0, 1'b1, 1'b0, 1'b0, 8'h0F, 8'hFF};
    vecs[7]  = '{16'h8000, 0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00};
    vecs[8]  = '{16'h9005, 0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h06};
    vecs[9]  = '{16'hB021, 3, 1'b0, 1'b1, 1'b0, 8'h06, 8'hE8};
    vecs[10] = '{16'hC0FF, 1, 1'b0, 1'b1, 1'b1, 8'hE8, 8'hE8};
    vecs[11] = '{16'hD01F, 0, 1'b0, 1'b1, 1'b0, 8'hE8, 8'h08};

    rst    = 1'b1;
    iack   = 1'b0;
    idata  = 16'h0000;
    stall  = 1'b0;
    jump   = 1'b0;
    branch = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ireq", 32'(ireq), 32'd0);
    check("reset exec", 32'(exec), 32'd0);
    check("reset pc", 32'(pc), 32'h00);
    check("reset instr", 32'(instr), 32'h0000);
    check("reset op", 32'(op), 32'h0);
    check("reset fault", 32'(fault), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_instr($sformatf("vec%0d", i), vecs[i].word, vecs[i].wait_n, vecs[i].j,
                vecs[i].b, vecs[i].s, vecs[i].exp_addr, vecs[i].exp_pc);
    end

    pc_m = 8'h08;
    for (int i = 0; i < 40; i++) begin
      w   = 16'($urandom);
      j   = ($urandom_range(3) == 0);
      b   = 1'($urandom);
      s   = ($urandom_range(3) == 0);
      nxt = ref_next(pc_m, w, j, b);
      run_instr($sformatf("rand%0d", i), w, $urandom_range(3), j, b, s, pc_m, nxt);
      pc_m = nxt;
    end

    // A reset during a fetch drops the request, and a later ack is ignored.
    budget = 20;
    while (!ireq && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("midfetch ireq_before", 32'(ireq), 32'd1);
    rst  = 1'b1;
    iack = 1'b0;
    @(negedge clk);
    check("midfetch ireq", 32'(ireq), 32'd0);
    check("midfetch pc", 32'(pc), 32'h00);
    check("midfetch exec", 32'(exec), 32'd0);
    rst   = 1'b0;
    stall = 1'b1;
    iack  = 1'b1;
    idata = 16'hFFFF;
    @(negedge clk);
    check("late_ack ireq", 32'(ireq), 32'd0);
    check("late_ack exec", 32'(exec), 32'd0);
    check("late_ack instr", 32'(instr), 32'h0000);
    @(negedge clk);
    check("late_ack instr2", 32'(instr), 32'h0000);
    stall = 1'b0;
    iack  = 1'b0;
    @(negedge clk);
    check("restart ireq", 32'(ireq), 32'd1);
    check("restart iaddr", 32'(iaddr), 32'h00);

    // Fetch with no ack: the watchdog trips after 4 cycles, or the fetch waits forever.
`ifdef FETCH_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      check("wd pending fault", 32'(fault), 32'd0);
      check("wd pending ireq", 32'(ireq), 32'd1);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      check("wd fault", 32'(fault), 32'd1);
      check("wd fault ireq", 32'(ireq), 32'd0);
      check("wd fault exec", 32'(exec), 32'd0);
      stall = 1'($urandom);
      iack  = 1'($urandom);
      @(negedge clk);
    end
    iack = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    check("wd fault cleared", 32'(fault), 32'd0);
    rst = 1'b0;
`else
    for (int k = 0; k < 10; k++) begin
      check("no_wd fault", 32'(fault), 32'd0);
      check("no_wd ireq", 32'(ireq), 32'd1);
      check("no_wd iaddr", 32'(iaddr), 32'h00);
      @(negedge clk);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
